ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AW, default 4: RAM address width (16 locations).
REQ-002 Parameter DW, default 8: RAM data width.
REQ-003 Parameter MAX_LOCK, default 8: maximum consecutive cycles one port may hold a lock.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 req_a, req_b  in  1  port request.
REQ-007 we_a, we_b  in  1  1 = write, 0 = read.
REQ-008 lock_a, lock_b  in  1  keep ownership after this transfer.
REQ-009 addr_a, addr_b  in  AW  access address.
REQ-010 wdata_a, wdata_b  in  DW  write data.
REQ-011 gnt_a, gnt_b  out  1  transfer accepted this cycle (req & gnt).
REQ-012 rvalid_a, rvalid_b  out  1  read data valid.
REQ-013 rdata_a, rdata_b  out  DW  read data; meaningful only with rvalid.
REQ-014 ram_we  out  1  to RAM write enable.
REQ-015 ram_addr  out  AW  to RAM address.
REQ-016 ram_din  out  DW  to RAM write data.
REQ-017 ram_dout  in  DW  from RAM; registered, valid the cycle after address presented.

Function
REQ-018 FSM states: IDLE, OWN_A, OWN_B.
REQ-019 IDLE: single requester wins; both requesting -> port not in last_served wins.
REQ-020 OWN_x: only port x eligible; the other port is not granted even if requesting.
REQ-021 At most one gnt high per cycle; gnt combinational from state, last_served, req.
REQ-022 Granted port's we/addr/wdata drive ram_we/ram_addr/ram_din in the same cycle; with no grant, ram_we=0, ram_addr=0, ram_din=0.
REQ-023 Accepted transfer with lock_x=1 -> next state OWN_x; with lock_x=0 -> next state IDLE.
REQ-024 lock_cnt counts cycles spent in OWN_x; when lock_cnt reaches MAX_LOCK-1, next state is IDLE regardless of lock_x.
REQ-025 OWN_x with req_x=0: no grant, lock_cnt still advances.
REQ-026 last_served updates to x whenever the FSM leaves OWN_x or a non-locked grant to x occurs.
REQ-027 Accepted read by x at cycle N -> rvalid_x=1 at cycle N+1 for exactly one cycle; rdata_x=ram_dout.
REQ-028 Writes produce no rvalid.
REQ-029 Back-to-back reads sustain one rvalid per cycle, zero bubbles.
REQ-030 A write followed next cycle by a read of the same address returns the new data.

Reset
REQ-031 rst_n low at an edge: state=IDLE, last_served=B, lock_cnt=0, rvalid_a=rvalid_b=0.
REQ-032 While rst_n low: gnt_a=gnt_b=0 and ram_we=0.
REQ-033 A read accepted in the cycle before reset asserts produces no rvalid.

Structure
REQ-034 Shared package ram_pkg holds AW, DW defaults and the FSM state enum.
REQ-035 Sub-module rr_pick2 (2-way round-robin picker: req_a, req_b, last_served -> winner) is the only sub-module.
REQ-036 Target size 120-250 RTL lines; no memory inside the block.

Verification
REQ-037 Write A: addr 3 data 8'h5A; next cycle read A addr 3 -> gnt_a both cycles, rvalid_a one cycle later, rdata_a=8'h5A.
REQ-038 req_a=req_b=1 (reads) for 4 cycles after reset -> grants A,B,A,B; rvalid follows each grant by one cycle.
REQ-039 A reads with lock_a=1 continuously while req_b=1, MAX_LOCK=8 -> 8 consecutive gnt_a, then gnt_b.
REQ-040 A locks, then drops req_a for 2 cycles with req_b=1 -> gnt_b=0 in both cycles; A keeps ownership.
REQ-041 A read accepted, rst_n low the following edge -> rvalid_a stays 0; after release A wins first arbitration.
REQ-042 Idle bus (no req) -> ram_we=0, ram_addr=0, no rvalid, RAM contents unchanged.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the two-port RAM arbiter.
//   AW_DEF, DW_DEF, MAX_LOCK_DEF : default address width, data width and lock budget
//   state_e                      : arbiter FSM states
//   port_e                       : identifies one of the two requesting ports
package ram_pkg;

  localparam int AW_DEF       = 4;
  localparam int DW_DEF       = 8;
  localparam int MAX_LOCK_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker.
//   req_a, req_b : requests from port A and port B
//   last_served  : port that was served most recently
//   winner       : chosen port; a lone requester wins, a tie goes to the port
//                  that was not served last. Meaningless when nobody requests.
module rr_pick2
  import ram_pkg::*;
(
  input  logic  req_a,
  input  logic  req_b,
  input  port_e last_served,
  output port_e winner
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = PORT_B;
    if (req_a && (!req_b || last_served == PORT_B)) begin
      winner = PORT_A;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates two request ports onto one external synchronous RAM.
//   clk, rst_n                   : clock, synchronous active-low reset
//   req_x/we_x/lock_x/addr_x/wdata_x : per-port request, write flag, lock, address, data
//   gnt_x                        : transfer accepted this cycle
//   rvalid_x/rdata_x             : read data, one cycle after an accepted read
//   ram_we/ram_addr/ram_din      : RAM command driven by the granted port
//   ram_dout                     : registered RAM read data
// A port that takes a grant with lock set owns the RAM for up to MAX_LOCK
// cycles in total, counting the acquiring transfer.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          we_a,
  input  logic          we_b,
  input  logic          lock_a,
  input  logic          lock_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int            CW        = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);

  state_e        state, state_nxt;
  port_e         last_served, last_nxt, winner;
  logic [CW-1:0] lock_cnt, cnt_nxt;
  logic          rvalid_a_q, rvalid_b_q;

  rr_pick2 u_pick (
    .req_a       (req_a),
    .req_b       (req_b),
    .last_served (last_served),
    .winner      (winner)
  );

  // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          gnt_a = req_a && (winner == PORT_A);
          gnt_b = req_b && (winner == PORT_B);
        end
        ST_OWN_A: gnt_a = req_a;
        ST_OWN_B: gnt_b = req_b;
        default: ;
      endcase
    end
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt_a) begin
      ram_we   = we_a;
      ram_addr = addr_a;
      ram_din  = wdata_a;
    end else if (gnt_b) begin
      ram_we   = we_b;
      ram_addr = addr_b;
      ram_din  = wdata_b;
    end
  end

  // lock_cnt is 1 in the first owned cycle (the acquiring transfer is the
  // lock's first cycle), so reaching MAX_LOCK-1 ends a MAX_LOCK-cycle hold.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = lock_cnt;
    last_nxt  = last_served;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (gnt_a) begin
          if (lock_a) begin
            state_nxt = ST_OWN_A;
            cnt_nxt   = CW'(1);
          end else begin
            last_nxt = PORT_A;
          end
        end else if (gnt_b) begin
          if (lock_b) begin
            state_nxt = ST_OWN_B;
            cnt_nxt   = CW'(1);
          end else begin
            last_nxt = PORT_B;
          end
        end
      end
      ST_OWN_A: begin
        cnt_nxt = lock_cnt + CW'(1);
        if (lock_cnt == LOCK_LAST || (gnt_a && !lock_a)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          last_nxt  = PORT_A;
        end
      end
      ST_OWN_B: begin
        cnt_nxt = lock_cnt + CW'(1);
        if (lock_cnt == LOCK_LAST || (gnt_b && !lock_b)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          last_nxt  = PORT_B;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_served <= PORT_B;
      lock_cnt    <= '0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_served <= last_nxt;
      lock_cnt    <= cnt_nxt;
      rvalid_a_q  <= gnt_a && !we_a;
      rvalid_b_q  <= gnt_b && !we_b;
    end
  end

  // A read accepted just before reset asserts must not surface, so the
  // registered valid is also masked by rst_n.
  assign rvalid_a = rvalid_a_q && rst_n;
  assign rvalid_b = rvalid_b_q && rst_n;
  assign rdata_a  = ram_dout;
  assign rdata_b  = ram_dout;

endmodule
